dco_tune_ctrl: RTL



---
 rtl/dco_tune_ctrl.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/dco_tune_ctrl.sv
// ADPLL loop controller: turns phase-detector UP/DN levels into coarse/fine DCO
// tuning words through a COARSE -> FINE -> LOCKED acquisition FSM.
module dco_tune_ctrl #(
  parameter int CTW_W      = 8,
  parameter int FTW_W      = 8,
  parameter int CTW_INIT   = 2**(CTW_W-1),
  parameter int COARSE_REV = 4,
  parameter int FINE_REV   = 8,
  parameter int UNLOCK_RUN = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             UP,
  input  logic             DN,
  input  logic             hold,
  output logic [CTW_W-1:0] CTW,
  output logic [FTW_W-1:0] FTW,
  output logic [1:0]       mode,
  output logic             lock
);

  localparam int MAX_A   = (COARSE_REV > FINE_REV) ? COARSE_REV : FINE_REV;
  localparam int MAX_CNT = (MAX_A > UNLOCK_RUN) ? MAX_A : UNLOCK_RUN;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);

  localparam logic [CTW_W-1:0] CTW_RST = CTW_W'(CTW_INIT);
  localparam logic [CTW_W-1:0] CTW_MAX = '1;
  localparam logic [FTW_W-1:0] FTW_MAX = '1;
  localparam logic [FTW_W-1:0] FTW_MID = {1'b1, {(FTW_W-1){1'b0}}};

  typedef enum logic [1:0] {
    COARSE = 2'd0,
    FINE   = 2'd1,
    LOCKED = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CTW_W-1:0]   ctw_q, ctw_d;
  logic [FTW_W-1:0]   ftw_q, ftw_d;
  logic               lock_q, lock_d;
  logic               dirValid_q, dirValid_d;
  logic               dir_q, dir_d;
  logic [CNT_W-1:0]   rev_q, rev_d;
  logic [CNT_W-1:0]   run_q, run_d;

  logic upEv, dnEv, ev, carry;

  assign upEv = UP & ~DN;
  assign dnEv = DN & ~UP;
  assign ev   = (upEv | dnEv) & ~hold;

  always_comb begin
    state_d    = state_q;
    ctw_d      = ctw_q;
    ftw_d      = ftw_q;
    dirValid_d = dirValid_q;
    dir_d      = dir_q;
    rev_d      = rev_q;
    run_d      = run_q;
    carry      = 1'b0;

    if (ev) begin
      // dir_q=1 means the last event was an up-event; counters saturate rather than wrap
      dirValid_d = 1'b1;
      dir_d      = upEv;
      if (dirValid_q && (dir_q != upEv)) begin
        rev_d = (rev_q == '1) ? rev_q : rev_q + 1'b1;
        run_d = CNT_W'(1);
      end else if (dirValid_q) begin
        rev_d = '0;
        run_d = (run_q == '1) ? run_q : run_q + 1'b1;
      end else begin
        rev_d = '0;
        run_d = CNT_W'(1);
      end

      case (state_q)
        COARSE: begin
          if (upEv) ctw_d = (ctw_q == CTW_MAX) ? ctw_q : ctw_q + 1'b1;
          else      ctw_d = (ctw_q == '0)      ? ctw_q : ctw_q - 1'b1;
          ftw_d = FTW_MID;
          if (rev_d == CNT_W'(COARSE_REV)) begin
            state_d = FINE;
            rev_d   = '0;
          end
        end
        default: begin
          // FTW wrap carries/borrows into CTW; at the CTW limits FTW saturates instead
          if (upEv) begin
            if (ftw_q != FTW_MAX)       ftw_d = ftw_q + 1'b1;
            else if (ctw_q == CTW_MAX)  ftw_d = FTW_MAX;
            else begin
              ftw_d = FTW_MID;
              ctw_d = ctw_q + 1'b1;
              carry = 1'b1;
            end
          end else begin
            if (ftw_q != '0)            ftw_d = ftw_q - 1'b1;
            else if (ctw_q == '0)       ftw_d = '0;
            else begin
              ftw_d = FTW_MID;
              ctw_d = ctw_q - 1'b1;
              carry = 1'b1;
            end
          end
          if (state_q == FINE && rev_d >= CNT_W'(FINE_REV)) begin
            state_d = LOCKED;
            rev_d   = '0;
            run_d   = '0;
          end else if (state_q == LOCKED && (run_d >= CNT_W'(UNLOCK_RUN) || carry)) begin
            state_d = FINE;
            rev_d   = '0;
            run_d   = '0;
          end
        end
      endcase
    end

    lock_d = (state_d == LOCKED);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= COARSE;
      ctw_q      <= CTW_RST;
      ftw_q      <= FTW_MID;
      lock_q     <= 1'b0;
      dirValid_q <= 1'b0;
      dir_q      <= 1'b0;
      rev_q      <= '0;
      run_q      <= '0;
    end else begin
      state_q    <= state_d;
      ctw_q      <= ctw_d;
      ftw_q      <= ftw_d;
      lock_q     <= lock_d;
      dirValid_q <= dirValid_d;
      dir_q      <= dir_d;
      rev_q      <= rev_d;
      run_q      <= run_d;
    end
  end

  assign CTW  = ctw_q;
  assign FTW  = ftw_q;
  assign mode = state_q;
  assign lock = lock_q;

endmodule
